// File: rtl/dmg_bus.sv
// DMG system bus: M-cycle clock enable, address decode / read mux, write strobes,
// boot-ROM overlay latch and the FF46 OAM DMA engine.
module dmg_bus #(
   parameter int CE_DIV    = 4,
   parameter int BOOT_SIZE = 256,
   parameter int DMA_LEN   = 160
) (
   input  logic        clk,
   input  logic        rst,
   output logic        cpu_ce,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_d_out,
   input  logic        cpu_write,
   output logic [7:0]  cpu_d_in,
   output logic [15:0] mem_addr,
   input  logic [7:0]  rom_d_rd,
   input  logic [7:0]  boot_d_rd,
   input  logic [7:0]  vram_d_rd,
   input  logic [7:0]  wram_d_rd,
   input  logic [7:0]  oam_d_rd,
   input  logic [7:0]  io_d_rd,
   input  logic [7:0]  hram_d_rd,
   output logic        vram_we,
   output logic        wram_we,
   output logic        io_we,
   output logic        hram_we,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_d_wr,
   output logic        oam_we,
   output logic        dma_active,
   output logic        boot_hidden
);
   localparam int          DIV_W    = $clog2(CE_DIV);
   localparam logic [16:0] BOOT_LIM = 17'(BOOT_SIZE);
   localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} dma_state_t;
   typedef enum logic [3:0] {
      R_NONE, R_ROM, R_BOOT, R_VRAM, R_WRAM, R_OAM, R_IO, R_HRAM, R_REG46, R_REG50
   } region_t;

   function automatic region_t decode(input logic [15:0] a, input logic hidden);
      region_t r;
      r = R_NONE;
      if (!a[15])                                r = (!hidden && ({1'b0, a} < BOOT_LIM)) ? R_BOOT : R_ROM;
      else if (a[15:13] == 3'b100)               r = R_VRAM;
      else if (a[15:14] == 2'b11 && a < 16'hFE00) r = R_WRAM;
      else if (a >= 16'hFE00 && a <= 16'hFE9F)   r = R_OAM;
      else if (a == 16'hFF46)                    r = R_REG46;
      else if (a == 16'hFF50)                    r = R_REG50;
      else if (a >= 16'hFF00 && a <= 16'hFF7F)   r = R_IO;
      else if (a == 16'hFFFF)                    r = R_IO;
      else if (a >= 16'hFF80)                    r = R_HRAM;
      return r;
   endfunction

   logic [DIV_W-1:0] div_reg;
   logic             ce_reg;
   logic             boot_hidden_reg;
   logic [7:0]       ff46_reg;
   logic [7:0]       src_reg, src_next;
   logic             pending_reg, pending_next;
   dma_state_t       state_reg, state_next;
   logic [7:0]       idx_reg, idx_next;

   logic        wr_ff46, wr_ff50;
   logic [15:0] dma_addr, cpu_eff;
   region_t     cpu_region, dma_region;
   logic [7:0]  dma_data;

   assign cpu_ce      = ce_reg;
   assign boot_hidden = boot_hidden_reg;
   assign dma_active  = (state_reg != S_IDLE);

   assign wr_ff46 = ce_reg & cpu_write & (cpu_addr == 16'hFF46);
   assign wr_ff50 = ce_reg & cpu_write & (cpu_addr == 16'hFF50) & (cpu_d_out != 8'h00) & ~dma_active;

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_reg         <= '0;
         ce_reg          <= 1'b0;
         boot_hidden_reg <= 1'b0;
         ff46_reg        <= 8'h00;
         src_reg         <= 8'h00;
         pending_reg     <= 1'b0;
         state_reg       <= S_IDLE;
         idx_reg         <= 8'h00;
      end else begin
         div_reg     <= div_reg + DIV_W'(1);
         ce_reg      <= (div_reg == DIV_W'(CE_DIV - 1));
         src_reg     <= src_next;
         pending_reg <= pending_next;
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         if (wr_ff50) boot_hidden_reg <= 1'b1;
         if (wr_ff46) ff46_reg <= cpu_d_out;
      end
   end

   // A pending FF46 write always wins, so a restart mid-transfer re-enters START.
   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      src_next     = src_reg;
      pending_next = pending_reg;
      if (ce_reg) begin
         if (pending_reg) begin
            state_next   = S_START;
            src_next     = (ff46_reg >= 8'hE0) ? ff46_reg - 8'h20 : ff46_reg;
            pending_next = 1'b0;
         end else begin
            case (state_reg)
               S_START: begin
                  state_next = S_XFER;
                  idx_next   = 8'h00;
               end
               S_XFER: begin
                  idx_next = idx_reg + 8'd1;
                  if (idx_reg == LAST_IDX) state_next = S_IDLE;
               end
               default: ;
            endcase
         end
      end
      if (wr_ff46) pending_next = 1'b1;
   end

   // Echo RAM E000-FDFF folds onto C000-DDFF.
   assign cpu_eff    = (cpu_addr >= 16'hE000 && cpu_addr < 16'hFE00) ?
                       {cpu_addr[15:14], 1'b0, cpu_addr[12:0]} : cpu_addr;
   assign dma_addr   = {src_reg, idx_reg};
   assign mem_addr   = dma_active ? dma_addr : cpu_eff;
   assign cpu_region = decode(cpu_addr, boot_hidden_reg);
   assign dma_region = decode(dma_addr, boot_hidden_reg);

   always_comb begin
      dma_data = 8'hFF;
      case (dma_region)
         R_ROM:   dma_data = rom_d_rd;
         R_BOOT:  dma_data = boot_d_rd;
         R_VRAM:  dma_data = vram_d_rd;
         R_WRAM:  dma_data = wram_d_rd;
         default: dma_data = 8'hFF;
      endcase
   end

   always_comb begin
      cpu_d_in = 8'hFF;
      if (!dma_active || cpu_region == R_HRAM) begin
         case (cpu_region)
            R_ROM:   cpu_d_in = rom_d_rd;
            R_BOOT:  cpu_d_in = boot_d_rd;
            R_VRAM:  cpu_d_in = vram_d_rd;
            R_WRAM:  cpu_d_in = wram_d_rd;
            R_OAM:   cpu_d_in = oam_d_rd;
            R_IO:    cpu_d_in = io_d_rd;
            R_HRAM:  cpu_d_in = hram_d_rd;
            R_REG46: cpu_d_in = ff46_reg;
            default: cpu_d_in = 8'hFF;
         endcase
      end
   end

   assign vram_we = cpu_write & ~dma_active & (cpu_region == R_VRAM);
   assign wram_we = cpu_write & ~dma_active & (cpu_region == R_WRAM);
   assign io_we   = cpu_write & ~dma_active & (cpu_region == R_IO);
   assign hram_we = cpu_write & (cpu_region == R_HRAM);

   assign oam_addr = dma_active ? idx_reg  : cpu_addr[7:0];
   assign oam_d_wr = dma_active ? dma_data : cpu_d_out;
   assign oam_we   = dma_active ? (state_reg == S_XFER) : (cpu_write & (cpu_region == R_OAM));
endmodule

// File: tb/tb_dmg_bus.sv
// Bench for dmg_bus: decode vectors from a table, DMA bytes checked through a scoreboard queue.
module tb_dmg_bus;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, cpu_write;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_d_out;
   logic [7:0]  rom_d_rd, boot_d_rd, vram_d_rd, wram_d_rd, oam_d_rd, io_d_rd, hram_d_rd;
   logic        cpu_ce, vram_we, wram_we, io_we, hram_we, oam_we, dma_active, boot_hidden;
   logic [7:0]  cpu_d_in, oam_addr, oam_d_wr;
   logic [15:0] mem_addr;
   logic        d8_ce, d8_vram_we, d8_wram_we, d8_io_we, d8_hram_we, d8_oam_we, d8_dma_active, d8_boot_hidden;
   logic [7:0]  d8_cpu_d_in, d8_oam_addr, d8_oam_d_wr;
   logic [15:0] d8_mem_addr;

   // Slave models: WRAM/VRAM return the low address byte with a fixed XOR.
   assign wram_d_rd = mem_addr[7:0] ^ 8'h5A;
   assign vram_d_rd = mem_addr[7:0] ^ 8'hA5;

   dmg_bus #(.CE_DIV(4)) dut (
      .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
      .cpu_write(cpu_write), .cpu_d_in(cpu_d_in), .mem_addr(mem_addr),
      .rom_d_rd(rom_d_rd), .boot_d_rd(boot_d_rd), .vram_d_rd(vram_d_rd), .wram_d_rd(wram_d_rd),
      .oam_d_rd(oam_d_rd), .io_d_rd(io_d_rd), .hram_d_rd(hram_d_rd),
      .vram_we(vram_we), .wram_we(wram_we), .io_we(io_we), .hram_we(hram_we),
      .oam_addr(oam_addr), .oam_d_wr(oam_d_wr), .oam_we(oam_we),
      .dma_active(dma_active), .boot_hidden(boot_hidden)
   );

   dmg_bus #(.CE_DIV(8)) dut8 (
      .clk(clk), .rst(rst), .cpu_ce(d8_ce), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
      .cpu_write(1'b0), .cpu_d_in(d8_cpu_d_in), .mem_addr(d8_mem_addr),
      .rom_d_rd(rom_d_rd), .boot_d_rd(boot_d_rd), .vram_d_rd(vram_d_rd), .wram_d_rd(wram_d_rd),
      .oam_d_rd(oam_d_rd), .io_d_rd(io_d_rd), .hram_d_rd(hram_d_rd),
      .vram_we(d8_vram_we), .wram_we(d8_wram_we), .io_we(d8_io_we), .hram_we(d8_hram_we),
      .oam_addr(d8_oam_addr), .oam_d_wr(d8_oam_d_wr), .oam_we(d8_oam_we),
      .dma_active(d8_dma_active), .boot_hidden(d8_boot_hidden)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  d;
      logic [15:0] m;
   } xfer_t;
   xfer_t exp_q[$];

   task automatic push_dma(input logic [7:0] src, input logic [7:0] xk);
      for (int i = 0; i < 160; i++) begin
         xfer_t e;
         e.a = 8'(i);
         e.d = 8'(i) ^ xk;
         e.m = {src, 8'(i)};
         exp_q.push_back(e);
      end
   endtask

   int pulse_cnt = 0, active_cnt = 0, start_cnt = 0;

   always @(negedge clk) begin
      if (cpu_ce && dma_active) begin
         active_cnt++;
         if (oam_we) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
               check("dma_unexpected_byte", {oam_addr, oam_d_wr, mem_addr}, 32'hxxxxxxxx);
            end else begin
               xfer_t e;
               e = exp_q.pop_front();
               check("dma_byte", {oam_addr, oam_d_wr, mem_addr}, e);
               $display("dma byte %0d: oam_addr=%h data=%h mem_addr=%h", pulse_cnt - 1, oam_addr, oam_d_wr, mem_addr);
            end
         end else begin
            start_cnt++;
         end
      end
   end

   task automatic wait_ce_edge();
      int t;
      for (t = 0; t < 64; t++) begin
         @(negedge clk);
         if (cpu_ce) break;
      end
      if (t == 64) check("ce_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   // Holds the write for one full M-cycle, released just after the sampling edge.
   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      wait_ce_edge();
      cpu_addr  = a;
      cpu_d_out = d;
      cpu_write = 1'b1;
      wait_ce_edge();
      cpu_write = 1'b0;
      $display("write %h <= %h", a, d);
   endtask

   task automatic wait_dma_done(input string name);
      int t;
      bit seen;
      seen = 0;
      for (t = 0; t < 4000; t++) begin
         @(negedge clk);
         if (dma_active) seen = 1;
         else if (seen) break;
      end
      check(name, t < 4000, 1);
   endtask

   task automatic wait_pulses(input int n);
      int t;
      for (t = 0; t < 4000; t++) begin
         @(posedge clk);
         if (pulse_cnt >= n) break;
      end
      check("pulse_wait", t < 4000, 1);
      #1;
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [7:0]  dout;
      logic [7:0]  din;
      logic [4:0]  we;     // {vram, wram, io, hram, oam}
      logic [15:0] maddr;
   } vec_t;
   vec_t vecs[30];

   initial begin
      int first4, first8, last4, last8;
      vecs[0]  = '{16'h0042, 1'b0, 8'h00, 8'h31, 5'b00000, 16'h0042};
      vecs[1]  = '{16'h0100, 1'b0, 8'h00, 8'hC3, 5'b00000, 16'h0100};
      vecs[2]  = '{16'h00FF, 1'b0, 8'h00, 8'h31, 5'b00000, 16'h00FF};
      vecs[3]  = '{16'h7FFF, 1'b0, 8'h00, 8'hC3, 5'b00000, 16'h7FFF};
      vecs[4]  = '{16'h8123, 1'b0, 8'h00, 8'h86, 5'b00000, 16'h8123};
      vecs[5]  = '{16'hA000, 1'b0, 8'h00, 8'hFF, 5'b00000, 16'hA000};
      vecs[6]  = '{16'hC010, 1'b0, 8'h00, 8'h4A, 5'b00000, 16'hC010};
      vecs[7]  = '{16'hE010, 1'b0, 8'h00, 8'h4A, 5'b00000, 16'hC010};
      vecs[8]  = '{16'hFDFF, 1'b0, 8'h00, 8'hA5, 5'b00000, 16'hDDFF};
      vecs[9]  = '{16'hFE00, 1'b0, 8'h00, 8'h44, 5'b00000, 16'hFE00};
      vecs[10] = '{16'hFE9F, 1'b0, 8'h00, 8'h44, 5'b00000, 16'hFE9F};
      vecs[11] = '{16'hFEA0, 1'b0, 8'h00, 8'hFF, 5'b00000, 16'hFEA0};
      vecs[12] = '{16'hFEFF, 1'b0, 8'h00, 8'hFF, 5'b00000, 16'hFEFF};
      vecs[13] = '{16'hFF00, 1'b0, 8'h00, 8'h99, 5'b00000, 16'hFF00};
      vecs[14] = '{16'hFF7F, 1'b0, 8'h00, 8'h99, 5'b00000, 16'hFF7F};
      vecs[15] = '{16'hFF80, 1'b0, 8'h00, 8'h77, 5'b00000, 16'hFF80};
      vecs[16] = '{16'hFFFE, 1'b0, 8'h00, 8'h77, 5'b00000, 16'hFFFE};
      vecs[17] = '{16'hFFFF, 1'b0, 8'h00, 8'h99, 5'b00000, 16'hFFFF};
      vecs[18] = '{16'hFF46, 1'b0, 8'h00, 8'h00, 5'b00000, 16'hFF46};
      vecs[19] = '{16'hFF50, 1'b0, 8'h00, 8'hFF, 5'b00000, 16'hFF50};
      vecs[20] = '{16'h8000, 1'b1, 8'h12, 8'hA5, 5'b10000, 16'h8000};
      vecs[21] = '{16'hC000, 1'b1, 8'h12, 8'h5A, 5'b01000, 16'hC000};
      vecs[22] = '{16'hE000, 1'b1, 8'h12, 8'h5A, 5'b01000, 16'hC000};
      vecs[23] = '{16'hFE10, 1'b1, 8'h12, 8'h44, 5'b00001, 16'hFE10};
      vecs[24] = '{16'hFF01, 1'b1, 8'h12, 8'h99, 5'b00100, 16'hFF01};
      vecs[25] = '{16'hFFFF, 1'b1, 8'h12, 8'h99, 5'b00100, 16'hFFFF};
      vecs[26] = '{16'hFF80, 1'b1, 8'h12, 8'h77, 5'b00010, 16'hFF80};
      vecs[27] = '{16'h0000, 1'b1, 8'h12, 8'h31, 5'b00000, 16'h0000};
      vecs[28] = '{16'hFEA0, 1'b1, 8'h12, 8'hFF, 5'b00000, 16'hFEA0};
      vecs[29] = '{16'hA000, 1'b1, 8'h12, 8'hFF, 5'b00000, 16'hA000};

      rst = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0000; cpu_d_out = 8'h00;
      rom_d_rd = 8'hC3; boot_d_rd = 8'h31; oam_d_rd = 8'h44; io_d_rd = 8'h99; hram_d_rd = 8'h77;

      repeat (2) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_outputs", {cpu_ce, d8_ce, dma_active, boot_hidden, oam_we,
                                 vram_we, wram_we, io_we, hram_we}, 0);
      end

      // Clock-enable placement and period for both divider settings.
      @(negedge clk);
      rst = 1'b1;
      first4 = 0; first8 = 0; last4 = -1; last8 = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (cpu_ce) begin
            if (first4 == 0) first4 = k;
            if (last4 >= 0) check("ce4_period", k - last4, 4);
            last4 = k;
         end
         if (d8_ce) begin
            if (first8 == 0) first8 = k;
            if (last8 >= 0) check("ce8_period", k - last8, 8);
            last8 = k;
         end
      end
      check("ce4_first", first4, 4);
      check("ce8_first", first8, 8);
      $display("ce first pulse: div4=%0d div8=%0d", first4, first8);

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         cpu_addr = vecs[i].addr; cpu_write = vecs[i].wr; cpu_d_out = vecs[i].dout;
         #1;
         check($sformatf("vec%0d_din", i), cpu_d_in, vecs[i].din);
         check($sformatf("vec%0d_we", i), {vram_we, wram_we, io_we, hram_we, oam_we}, vecs[i].we);
         check($sformatf("vec%0d_maddr", i), mem_addr, vecs[i].maddr);
         $display("vec %0d: addr=%h wr=%0b din=%h we=%b mem_addr=%h", i, cpu_addr, cpu_write,
                  cpu_d_in, {vram_we, wram_we, io_we, hram_we, oam_we}, mem_addr);
      end
      @(negedge clk);
      cpu_addr = 16'hFE10; cpu_d_out = 8'h5C; cpu_write = 1'b1;
      #1;
      check("oam_cpu_port", {oam_addr, oam_d_wr, 7'd0, oam_we}, {8'h10, 8'h5C, 8'h01});
      cpu_write = 1'b0;

      // Boot overlay: zero write keeps it, non-zero hides it.
      bus_write(16'hFF50, 8'h00);
      cpu_addr = 16'h0042; #1;
      check("boot_keep_din", cpu_d_in, 8'h31);
      check("boot_keep_flag", boot_hidden, 0);
      bus_write(16'hFF50, 8'h01);
      cpu_addr = 16'h0042; #1;
      check("boot_hide_din", cpu_d_in, 8'hC3);
      check("boot_hide_flag", boot_hidden, 1);

      // DMA from C100 with CPU access rules checked during the transfer.
      pulse_cnt = 0; active_cnt = 0; start_cnt = 0;
      push_dma(8'hC1, 8'h5A);
      bus_write(16'hFF46, 8'hC1);
      check("dma_not_yet", dma_active, 0);
      wait_ce_edge();
      check("dma_rise", dma_active, 1);
      cpu_addr = 16'h8000; cpu_write = 1'b0; #1;
      check("dma_rd_vram", cpu_d_in, 8'hFF);
      cpu_write = 1'b1; #1;
      check("dma_wr_vram", vram_we, 0);
      cpu_addr = 16'hC000; #1;
      check("dma_wr_wram", wram_we, 0);
      cpu_addr = 16'hFF90; cpu_write = 1'b0; #1;
      check("dma_rd_hram", cpu_d_in, 8'h77);
      cpu_write = 1'b1; #1;
      check("dma_wr_hram", hram_we, 1);
      cpu_write = 1'b0; cpu_addr = 16'hFF46; #1;
      check("dma_rd_ff46", cpu_d_in, 8'hFF);
      cpu_addr = 16'h0000;
      wait_dma_done("dma1_done");
      check("dma1_pulses", pulse_cnt, 160);
      check("dma1_active_mcycles", active_cnt, 161);
      check("dma1_start_cycles", start_cnt, 1);
      check("dma1_queue_empty", exp_q.size(), 0);
      cpu_addr = 16'hFF46; #1;
      check("ff46_readback", cpu_d_in, 8'hC1);

      // Echo-region source folds to DE00.
      pulse_cnt = 0; active_cnt = 0; start_cnt = 0;
      push_dma(8'hDE, 8'h5A);
      bus_write(16'hFF46, 8'hFE);
      wait_dma_done("dma2_done");
      check("dma2_pulses", pulse_cnt, 160);
      check("dma2_queue_empty", exp_q.size(), 0);

      // Restart at byte 50: bytes 50 and 51 still come from C0, then START, then 8000.
      pulse_cnt = 0; active_cnt = 0; start_cnt = 0;
      push_dma(8'hC0, 8'h5A);
      bus_write(16'hFF46, 8'hC0);
      wait_pulses(50);
      while (exp_q.size() > 2) void'(exp_q.pop_back());
      push_dma(8'h80, 8'hA5);
      cpu_addr = 16'hFF46; cpu_d_out = 8'h80; cpu_write = 1'b1;
      wait_ce_edge();
      cpu_write = 1'b0;
      $display("write ff46 <= 80 (restart)");
      wait_dma_done("dma3_done");
      check("dma3_pulses", pulse_cnt, 212);
      check("dma3_active_mcycles", active_cnt, 214);
      check("dma3_start_cycles", start_cnt, 2);
      check("dma3_queue_empty", exp_q.size(), 0);

      // Reset in the middle of a transfer.
      pulse_cnt = 0;
      push_dma(8'hC0, 8'h5A);
      bus_write(16'hFF46, 8'hC0);
      wait_pulses(10);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_abort", {oam_we, dma_active}, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rst_hold", {cpu_ce, oam_we, dma_active}, 0);
      end
      check("rst_pulses", pulse_cnt, 10);
      check("rst_boot_flag", boot_hidden, 0);
      exp_q.delete();
      rst = 1'b1;
      cpu_addr = 16'hFF46; #1;
      check("rst_ff46", cpu_d_in, 8'h00);
      cpu_addr = 16'h0042; #1;
      check("rst_boot_din", cpu_d_in, 8'h31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
